// File: rtl/video_line_fetcher.sv
// Prefetches the next display line from pixel memory into a ping-pong line buffer, one line ahead,
// and streams buffered pixels out with the syncs delayed by one cycle.
module video_line_fetcher #(
  parameter int H_RES   = 640,
  parameter int V_RES   = 480,
  parameter int H_TOTAL = 800,
  parameter int V_TOTAL = 525,
  parameter int DATA_W  = 12,
  parameter int ADDR_W  = 19
) (
  input  logic                       i_clk_pxl,
  input  logic                       i_reset_n,
  input  logic [$clog2(H_TOTAL)-1:0] i_sx,
  input  logic [$clog2(V_TOTAL)-1:0] i_sy,
  input  logic                       i_de,
  input  logic                       i_hsync,
  input  logic                       i_vsync,
  input  logic                       i_nf,
  output logic                       o_rd_req,
  output logic [ADDR_W-1:0]          o_rd_addr,
  input  logic                       i_rd_ready,
  input  logic                       i_rd_valid,
  input  logic [DATA_W-1:0]          i_rd_data,
  output logic [DATA_W-1:0]          o_rgb,
  output logic                       o_de,
  output logic                       o_hsync,
  output logic                       o_vsync,
  output logic                       o_busy,
  output logic                       o_underrun
);

  localparam int SX_W  = $clog2(H_TOTAL);
  localparam int SY_W  = $clog2(V_TOTAL);
  localparam int IDX_W = $clog2(H_RES);
  localparam int CNT_W = $clog2(H_RES + 1);

  localparam logic [SY_W-1:0]  SY_LAST  = SY_W'(V_TOTAL - 1);
  localparam logic [SY_W-1:0]  SY_PRE   = SY_W'(V_RES - 1);
  localparam logic [SX_W-1:0]  SX_HRES  = SX_W'(H_RES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(H_RES - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_REQ   = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [CNT_W-1:0]    req_cnt_q, req_cnt_d;
  logic [CNT_W-1:0]    wr_cnt_q, wr_cnt_d;
  logic                buf_sel_q, buf_sel_d;
  logic                underrun_q, underrun_d;
  logic [DATA_W-1:0]   rgb_q, rgb_d;
  logic                de_q, hsync_q, vsync_q;

  logic                trig;
  logic [SY_W-1:0]     tgt_line;
  logic [ADDR_W-1:0]   base_addr;
  logic                wr_en;

  logic [DATA_W-1:0]   line_mem [2][H_RES];

  // Line after the last blanking line wraps to line 0 of the next frame.
  assign trig      = (i_sx == '0) && ((i_sy == SY_LAST) || (i_sy < SY_PRE));
  assign tgt_line  = (i_sy == SY_LAST) ? '0 : i_sy + SY_W'(1);
  assign base_addr = ADDR_W'(tgt_line) * ADDR_W'(H_RES);

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    req_cnt_d = req_cnt_q;
    wr_cnt_d  = wr_cnt_q;
    buf_sel_d = buf_sel_q;
    wr_en     = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (trig) begin
          state_d   = S_REQ;
          addr_d    = base_addr;
          req_cnt_d = '0;
          wr_cnt_d  = '0;
          buf_sel_d = tgt_line[0];
        end
      end
      S_REQ: begin
        if (i_rd_ready) begin
          addr_d    = addr_q + ADDR_W'(1);
          req_cnt_d = req_cnt_q + CNT_W'(1);
          if (req_cnt_q == CNT_LAST) begin
            state_d = S_DRAIN;
          end
        end
      end
      S_DRAIN: begin
      end
      default: state_d = S_IDLE;
    endcase

    // Returned words land in order; the last one ends the fetch whatever the request side is doing.
    if ((state_q != S_IDLE) && i_rd_valid) begin
      wr_en    = 1'b1;
      wr_cnt_d = wr_cnt_q + CNT_W'(1);
      if (wr_cnt_q == CNT_LAST) begin
        state_d = S_IDLE;
      end
    end
  end

  // A trigger that finds a fetch still running is an underrun; setting beats the new-frame clear.
  assign underrun_d = (trig && (state_q != S_IDLE)) || (underrun_q && !i_nf);

  always_comb begin
    rgb_d = '0;
    if (i_de && (i_sx < SX_HRES)) begin
      rgb_d = line_mem[i_sy[0]][i_sx[IDX_W-1:0]];
    end
  end

  always_ff @(posedge i_clk_pxl or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q    <= S_IDLE;
      addr_q     <= '0;
      req_cnt_q  <= '0;
      wr_cnt_q   <= '0;
      buf_sel_q  <= 1'b0;
      underrun_q <= 1'b0;
      rgb_q      <= '0;
      de_q       <= 1'b0;
      hsync_q    <= 1'b0;
      vsync_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      req_cnt_q  <= req_cnt_d;
      wr_cnt_q   <= wr_cnt_d;
      buf_sel_q  <= buf_sel_d;
      underrun_q <= underrun_d;
      rgb_q      <= rgb_d;
      de_q       <= i_de;
      hsync_q    <= i_hsync;
      vsync_q    <= i_vsync;
    end
  end

  // Fetch and display always address opposite halves, so no read/write collision handling is needed.
  always_ff @(posedge i_clk_pxl) begin
    if (wr_en) begin
      line_mem[buf_sel_q][wr_cnt_q[IDX_W-1:0]] <= i_rd_data;
    end
  end

  assign o_rd_req   = (state_q == S_REQ);
  assign o_rd_addr  = addr_q;
  assign o_busy     = (state_q != S_IDLE);
  assign o_underrun = underrun_q;
  assign o_rgb      = rgb_q;
  assign o_de       = de_q;
  assign o_hsync    = hsync_q;
  assign o_vsync    = vsync_q;

endmodule

// File: tb/tb_video_line_fetcher.sv
// Randomized bench for video_line_fetcher on a reduced video geometry, checked against a line-level model.
module tb_video_line_fetcher;

  localparam int H_RES   = 16;
  localparam int V_RES   = 6;
  localparam int H_TOTAL = 24;
  localparam int V_TOTAL = 9;
  localparam int DATA_W  = 12;
  localparam int ADDR_W  = 7;
  localparam int SX_W    = $clog2(H_TOTAL);
  localparam int SY_W    = $clog2(V_TOTAL);
  localparam int FRAME   = H_TOTAL * V_TOTAL;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [SX_W-1:0]   sx;
  logic [SY_W-1:0]   sy;
  logic              de, hs, vs, nf;
  logic              rd_req;
  logic [ADDR_W-1:0] rd_addr;
  logic              rd_ready, rd_valid;
  logic [DATA_W-1:0] rd_data;
  logic [DATA_W-1:0] rgb;
  logic              o_de, o_hs, o_vs, busy, und;

  video_line_fetcher #(
    .H_RES(H_RES), .V_RES(V_RES), .H_TOTAL(H_TOTAL), .V_TOTAL(V_TOTAL),
    .DATA_W(DATA_W), .ADDR_W(ADDR_W)
  ) u_dut (
    .i_clk_pxl(clk), .i_reset_n(rst_n), .i_sx(sx), .i_sy(sy), .i_de(de),
    .i_hsync(hs), .i_vsync(vs), .i_nf(nf), .o_rd_req(rd_req), .o_rd_addr(rd_addr),
    .i_rd_ready(rd_ready), .i_rd_valid(rd_valid), .i_rd_data(rd_data), .o_rgb(rgb),
    .o_de(o_de), .o_hsync(o_hs), .o_vsync(o_vs), .o_busy(busy), .o_underrun(und)
  );

  always #5 clk = ~clk;

  typedef struct { int addr; int due; } rsp_t;
  rsp_t rq[$];

  int total, bad, cyc, gsx, gsy;
  bit rst_drv;
  int lat_min, lat_max, rdy_mode, salt, last_due, max_addr;

  // Model: what each line buffer holds, and the fetch in flight as "line L, n requested, n written".
  logic [DATA_W-1:0] mbuf [2][H_RES];
  bit                mknown [2][H_RES];
  bit m_active;
  int m_line, m_reqs, m_wr;

  bit have_exp, exp_rgb_known, exp_de, exp_hs, exp_vs, exp_und;
  int exp_rgb;
  bit phase1, pin_on, pin_addr0, watch_und, seen_und;
  int pin_val;
  string pin_name;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int mem_word(input int a);
    return (a + salt) & ((1 << DATA_W) - 1);
  endfunction

  // Model of what the upcoming clock edge does, using the inputs now applied.
  task automatic model_edge();
    int lat, due, b, L, ix, iy;
    bit exp_req, trig, was_active;
    exp_req = m_active && (m_reqs < H_RES);
    chk("rd_req", int'(rd_req), int'(exp_req));
    chk("busy", int'(busy), int'(m_active));
    if (rd_req && exp_req)
      chk("rd_addr", int'(rd_addr), (m_line * H_RES + m_reqs) % (1 << ADDR_W));
    if (rd_req && rd_ready) begin
      lat = $urandom_range(lat_max, lat_min);
      due = cyc + lat;
      if (due <= last_due) due = last_due + 1;
      last_due = due;
      rq.push_back('{addr: int'(rd_addr), due: due});
      if (int'(rd_addr) > max_addr) max_addr = int'(rd_addr);
      if (exp_req) m_reqs++;
    end

    ix = int'(sx);
    iy = int'(sy);
    exp_rgb = 0;
    exp_rgb_known = 1'b1;
    if (de && ix < H_RES) begin
      exp_rgb = int'(mbuf[iy % 2][ix]);
      exp_rgb_known = mknown[iy % 2][ix];
    end

    trig = (ix == 0) && ((iy == V_TOTAL - 1) || (iy < V_RES - 1));
    was_active = m_active;
    exp_und = (trig && was_active) || (exp_und && !nf);
    if (m_active && rd_valid) begin
      b = m_line % 2;
      mbuf[b][m_wr] = rd_data;
      mknown[b][m_wr] = 1'b1;
      m_wr++;
      if (m_wr == H_RES) m_active = 1'b0;
    end
    if (trig && !was_active) begin
      L = (iy == V_TOTAL - 1) ? 0 : iy + 1;
      m_active = 1'b1;
      m_line = L;
      m_reqs = 0;
      m_wr = 0;
    end
    exp_de = de;
    exp_hs = hs;
    exp_vs = vs;
    have_exp = 1'b1;

    pin_on = 1'b0;
    pin_addr0 = 1'b0;
    if (phase1) begin
      if (iy == 5 && ix == 10) begin pin_on = 1'b1; pin_val = 'h05A; pin_name = "line5_px10"; end
      if (iy == 0 && ix == 0)  begin pin_on = 1'b1; pin_val = 'h000; pin_name = "line0_px0"; end
      if (iy == 0 && ix == 15) begin pin_on = 1'b1; pin_val = 'h00F; pin_name = "line0_px15"; end
      if (iy == V_TOTAL - 1 && ix == 0 && !was_active) pin_addr0 = 1'b1;
    end
  endtask

  task automatic step();
    @(negedge clk);
    if (have_exp && rst_n) begin
      if (exp_rgb_known) chk("rgb", int'(rgb), exp_rgb);
      chk("de", int'(o_de), int'(exp_de));
      chk("hsync", int'(o_hs), int'(exp_hs));
      chk("vsync", int'(o_vs), int'(exp_vs));
      chk("underrun", int'(und), int'(exp_und));
      if (pin_on) chk(pin_name, int'(rgb), pin_val);
      if (pin_addr0) begin
        chk("prefetch_req", int'(rd_req), 1);
        chk("prefetch_addr0", int'(rd_addr), 0);
      end
      if (watch_und && und) seen_und = 1'b1;
    end

    gsx++;
    if (gsx == H_TOTAL) begin
      gsx = 0;
      gsy++;
      if (gsy == V_TOTAL) gsy = 0;
    end
    sx = SX_W'(gsx);
    sy = SY_W'(gsy);
    de = (gsx < H_RES) && (gsy < V_RES);
    hs = (gsx >= H_RES + 2) && (gsx < H_RES + 5);
    vs = (gsy == V_RES + 1);
    nf = (gsx == 0) && (gsy == 0);
    rst_n = rst_drv;
    case (rdy_mode)
      0:       rd_ready = 1'b1;
      1:       rd_ready = !rd_ready;
      default: rd_ready = 1'($urandom_range(1, 0));
    endcase
    rd_valid = 1'b0;
    rd_data = DATA_W'($urandom);
    if (rst_n && rq.size() > 0 && rq[0].due <= cyc) begin
      rd_valid = 1'b1;
      rd_data = DATA_W'(mem_word(rq[0].addr));
      void'(rq.pop_front());
    end

    if (rst_n) model_edge();
    else begin
      have_exp = 1'b0;
      pin_on = 1'b0;
      pin_addr0 = 1'b0;
    end
    cyc++;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic reset_mid_fetch();
    int n;
    n = 0;
    while (!(rd_req && gsx >= H_RES / 2) && n < 1000) begin
      step();
      n++;
    end
    chk("reset_wait_for_req", (n < 1000) ? 1 : 0, 1);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    rst_drv = 1'b0;
    #1;
    chk("rst_async_rd_req", int'(rd_req), 0);
    chk("rst_async_busy", int'(busy), 0);
    chk("rst_async_rgb", int'(rgb), 0);
    chk("rst_async_rd_addr", int'(rd_addr), 0);
    chk("rst_async_underrun", int'(und), 0);
    m_active = 1'b0;
    rq.delete();
    last_due = 0;
    have_exp = 1'b0;
    exp_und = 1'b0;
    rd_valid = 1'b0;
    pin_on = 1'b0;
    pin_addr0 = 1'b0;
    run(2);
    rst_drv = 1'b1;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not end, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  initial begin
    total = 0; bad = 0; cyc = 0;
    rst_n = 1'b0; rst_drv = 1'b0;
    sx = '0; sy = '0; de = 1'b0; hs = 1'b0; vs = 1'b0; nf = 1'b0;
    rd_ready = 1'b1; rd_valid = 1'b0; rd_data = '0;
    rdy_mode = 0; lat_min = 3; lat_max = 3; salt = 0; last_due = 0; max_addr = 0;
    m_active = 1'b0; m_line = 0; m_reqs = 0; m_wr = 0;
    have_exp = 1'b0; exp_und = 1'b0; phase1 = 1'b1;
    pin_on = 1'b0; pin_addr0 = 1'b0; watch_und = 1'b0; seen_und = 1'b0;
    for (int b = 0; b < 2; b++)
      for (int i = 0; i < H_RES; i++) mknown[b][i] = 1'b0;
    // Positioned so the first step after reset presents sy=V_TOTAL-1, sx=0.
    gsx = H_TOTAL - 4;
    gsy = V_TOTAL - 2;

    run(3);
    chk("reset_rd_req", int'(rd_req), 0);
    chk("reset_rd_addr", int'(rd_addr), 0);
    chk("reset_rgb", int'(rgb), 0);
    chk("reset_de", int'(o_de), 0);
    chk("reset_busy", int'(busy), 0);
    chk("reset_underrun", int'(und), 0);
    rst_drv = 1'b1;

    // Ideal memory: data = address, 3-cycle latency, always ready.
    watch_und = 1'b1; seen_und = 1'b0;
    run(2 * FRAME);
    chk("ideal_underrun_seen", int'(seen_und), 0);
    chk("ideal_max_addr", max_addr, H_RES * V_RES - 1);
    phase1 = 1'b0;

    // Backpressure: ready toggles, 4-cycle latency; a fetch overruns the line period.
    rdy_mode = 1; lat_min = 4; lat_max = 4; salt = $urandom_range(4095, 1);
    seen_und = 1'b0;
    run(FRAME);
    chk("backpressure_underrun_seen", int'(seen_und), 1);

    // Recovery: the next new-frame pulse clears the flag and it stays clear.
    rdy_mode = 0; lat_min = 3; lat_max = 3;
    run(FRAME + 30);
    chk("underrun_cleared_by_nf", int'(und), 0);
    seen_und = 1'b0;
    run(FRAME - 30);
    chk("underrun_stays_clear", int'(seen_und), 0);
    watch_und = 1'b0;

    // Random ready and latency.
    rdy_mode = 2; lat_min = 1; lat_max = 5; salt = $urandom_range(4095, 1);
    run(2 * FRAME);

    // Reset in the middle of a request burst, then a clean frame.
    rdy_mode = 0; lat_min = 2; lat_max = 3;
    reset_mid_fetch();
    run(FRAME + 10);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/video_line_fetcher.md
# video_line_fetcher

Line-prefetch controller between the pixel-timing generator and a pixel memory (frame buffer). Using the generator's `sx`/`sy` position, it fetches each upcoming display line one line ahead over a request/valid memory port into a ping-pong line buffer. During the active area it streams RGB pixels out with the sync signals re-aligned. An underrun is flagged whenever a fetch cannot finish within one line period.

## Interface
- `H_RES`, 640: active pixels per line
- `V_RES`, 480: active lines per frame
- `H_TOTAL`, 800: pixels per line including blanking
- `V_TOTAL`, 525: lines per frame including blanking
- `DATA_W`, 12: pixel width (RGB444)
- `ADDR_W`, 19: memory address width; must satisfy `2**ADDR_W >= H_RES*V_RES`
- `i_clk_pxl`, in, 1: pixel clock; the only clock
- `i_reset_n`, in, 1: asynchronous active-low reset
- `i_sx`, in, `$clog2(H_TOTAL)`: current pixel column from the generator
- `i_sy`, in, `$clog2(V_TOTAL)`: current line from the generator
- `i_de`, in, 1: generator data enable
- `i_hsync`, `i_vsync`, in, 1 each: generator syncs
- `i_nf`, in, 1: one-cycle new-frame pulse
- `o_rd_req`, out, 1: memory read request
- `o_rd_addr`, out, `ADDR_W`: read word address
- `i_rd_ready`, in, 1: memory accepts the request this cycle
- `i_rd_valid`, in, 1: read data valid; data returns in request order with arbitrary latency
- `i_rd_data`, in, `DATA_W`: read data
- `o_rgb`, out, `DATA_W`: output pixel
- `o_de`, `o_hsync`, `o_vsync`, out, 1 each: `i_de`/`i_hsync`/`i_vsync` delayed by 1 cycle
- `o_busy`, out, 1: a fetch is in progress
- `o_underrun`, out, 1: sticky error flag; cleared by `i_nf`

## Operation
- Storage is two line buffers, each `H_RES` × `DATA_W`. Display line n is held in buffer `n[0]`.
- **Fetch trigger:** evaluated on the cycle where `i_sx == 0`.
  - If `i_sy == V_TOTAL-1`, fetch line 0.
  - Else if `i_sy < V_RES-1`, fetch line `i_sy+1`.
  - Otherwise there is no trigger.
- **Fetch addressing:**
  - Target line L is written into buffer `L[0]`.
  - Addresses run from `L*H_RES` to `L*H_RES + H_RES-1`, ascending.
  - The base address is formed with a registered multiply or an accumulator, truncated to `ADDR_W`.
- **FSM:**
  - **IDLE:** a trigger latches L, clears `req_cnt` and `wr_cnt`, and moves to REQ.
  - **REQ:** `o_rd_req = 1`. Each cycle with `o_rd_req && i_rd_ready` increments `req_cnt` and advances `o_rd_addr`. After the `H_RES`-th accepted request, move to DRAIN.
  - **DRAIN:** `o_rd_req = 0`. Wait for the remaining data.
  - In REQ and DRAIN, each `i_rd_valid` writes `i_rd_data` to `buf[L[0]][wr_cnt]` and increments `wr_cnt`. When `wr_cnt` reaches `H_RES`, go to IDLE.
- **`o_busy`:** high in REQ and DRAIN.
- **Address/valid stability:** `o_rd_addr` must be held stable while `o_rd_req && !i_rd_ready`. `i_rd_valid` is ignored in IDLE.
- **Trigger while busy:**
  - Sets `o_underrun`.
  - The current fetch continues and is not restarted.
  - The new line is not fetched, so its buffer keeps stale data.
- **Display path:**
  - When `i_de = 1`, `o_rgb <= buf[i_sy[0]][i_sx]`.
  - Otherwise `o_rgb <= 0`.
- **`o_underrun` update priority:**
  - `i_nf` clears the flag.
  - An underrun in the same cycle as `i_nf` sets it; set wins.
- **Reset:**
  - Asynchronous, from any state.
  - FSM goes to IDLE; counters clear.
  - Outputs `o_rd_req`, `o_rd_addr`, `o_rgb`, `o_de`, `o_hsync`, `o_vsync`, `o_busy`, `o_underrun` all reset to 0.
  - Buffer contents are not reset.
  - The memory must share the same reset, so no stale data is returned after reset.

## Timing
- **Pixel latency:** 1 cycle from `i_sx`/`i_sy`/`i_de` to `o_rgb`/`o_de`. The syncs are delayed identically, so they stay aligned.
- **Request timing:**
  - First `o_rd_req` is asserted 1 cycle after the trigger cycle.
  - With `i_rd_ready` tied to 1, H_RES requests are issued on H_RES consecutive cycles.
- **Fetch budget:** the fetch must complete before the next `i_sx == 0`, i.e. within `H_TOTAL-1` cycles. With one word per cycle, the memory latency margin is `H_TOTAL - H_RES - 2`, which is 158 for the defaults.
- **Underrun timing:** `o_underrun` rises 1 cycle after the offending trigger cycle.
- **Buffer write-to-read:** a write in cycle t is readable by the display path in cycle t+1. There is no read/write conflict, because the display and the fetch always use opposite buffers.
- **Address wrap:** the last address of line `V_RES-1` is `H_RES*V_RES-1`, which is 307199 for the defaults. There is no wrap within a frame.

## Test plan
- **Full frame, ideal memory.** Setup: memory returns data equal to `addr[11:0]` with 3-cycle latency; `i_rd_ready = 1`. Required: at line 5, `sx = 10`, `o_rgb = (5*640+10)[11:0] = 0xC8A`, one cycle later. `o_underrun` stays 0 for 2 frames.
- **Frame-start prefetch.** Stimulus: at `sy = 524`, `sx = 0`. Required: `o_rd_addr = 0` on the next cycle; line 0 pixel 0 appears as `o_rgb = 0x000`; line 0 pixel 639 appears as `0x27F`.
- **Backpressure.** Setup: `i_rd_ready` toggles 1/0 every cycle, with 4-cycle latency. Required: `o_rd_addr` holds across each stall; 640 requests take 1279 cycles. That exceeds 799, so `o_underrun = 1` at the next `sx = 0`, and the current fetch still completes with `wr_cnt = 640`.
- **Underrun clear.** Stimulus: after the previous case, restore `i_rd_ready = 1` and pulse `i_nf`. Required: `o_underrun = 0` and stays 0 for the next frame.
- **Reset mid-fetch.** Stimulus: assert `i_reset_n = 0` at `sx = 300` during REQ. Required: `o_rd_req`, `o_busy`, and `o_rgb` are 0 immediately, without waiting for a clock edge. After release, no request is issued until the next trigger.
- **Blanking.** Condition: `sy` from 480 to 523 and `sx` from 640 to 799. Required: `o_rgb = 0`, `o_de = 0`, and no fetch triggers for `sy` from 479 to 523.
